pwmdir_capture: RTL and testbench

Measures an incoming PWM + DIR signal pair and returns a signed duty value, period and status in FPGA clock cycles. It is the receive-side counterpart of the joint PWM/DIR generator. It sits between external PWM/DIR pins (e.g. from a foreign motion controller or a looped-back joint output) and the LinuxCNC feedback register set. Each completed PWM period produces one signed measurement plus a one-cycle strobe.

---
 rtl/pwmdir_pkg.sv | 25 ++
 rtl/pwmdir_capture_if.sv | 31 +++
 rtl/pwmdir_in_sync.sv | 57 +++++
 rtl/pwmdir_capture.sv | 150 +++++++++++++++
 tb/tb_pwmdir_capture.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pwmdir_pkg.sv
// pwmdir_pkg -- definitions shared by the PWM/DIR capture block and the
// joint PWM/DIR generator: counter width, capture FSM states and the
// direction sign convention (DIR = 1 means a positive value).
package pwmdir_pkg;

  localparam int unsigned CNT_W = 32;

  typedef logic [CNT_W-1:0]        cnt_t;
  typedef logic signed [CNT_W-1:0] value_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic DIR_POSITIVE = 1'b1;

  // Attach the direction sign to a magnitude (two's-complement negation).
  // Magnitudes stay below 2^31, so the negation cannot overflow.
  function automatic value_t apply_dir(input logic dir, input cnt_t mag);
    return (dir == DIR_POSITIVE) ? value_t'(mag) : -value_t'(mag);
  endfunction

endpackage

// File: rtl/pwmdir_capture_if.sv
// pwmdir_capture_if -- groups the capture block's pins and feedback bus.
//   enable         measurement enable (0 forces IDLE, zeroes outputs)
//   PWM, DIR       asynchronous input pins (DIR = 1 positive)
//   valueFeedback  signed high time in cycles
//   periodFeedback rising-to-rising period in cycles
//   valid          one-cycle strobe per published measurement
//   timeout        sticky dead-input flag, cleared on the next publish
// Modports: master drives enable/pins and reads feedback; slave is the
// capture block itself.
interface pwmdir_capture_if;
  import pwmdir_pkg::*;

  logic   enable;
  logic   PWM;
  logic   DIR;
  value_t valueFeedback;
  cnt_t   periodFeedback;
  logic   valid;
  logic   timeout;

  modport master (
    output enable, PWM, DIR,
    input  valueFeedback, periodFeedback, valid, timeout
  );

  modport slave (
    input  enable, PWM, DIR,
    output valueFeedback, periodFeedback, valid, timeout
  );

endinterface

// File: rtl/pwmdir_in_sync.sv
// pwmdir_in_sync -- 2-FF synchronizer for one asynchronous pin, followed by
// an optional glitch filter (compiled in with PWMDIR_CAPTURE_FILTER_EN).
//   clk, rst  system clock, synchronous active-high reset
//   din       asynchronous pin
//   dout      synchronized (and, if enabled, filtered) level
// With the filter, dout follows the synchronized level only after
// FILTER_LEN consecutive identical samples, adding FILTER_LEN cycles of
// latency. FILTER_LEN exists only when the filter is compiled in.
module pwmdir_in_sync
`ifdef PWMDIR_CAPTURE_FILTER_EN
#(
  parameter int unsigned FILTER_LEN = 4
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the
  // two-stage synchronizer into a single flop.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], din};
  end

`ifdef PWMDIR_CAPTURE_FILTER_EN
  localparam int unsigned RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [RUN_W-1:0] run_q;   // samples seen that disagree with filt_q
  logic             filt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync_q[1] == filt_q) begin
      run_q <= '0;
    end else if (run_q == RUN_W'(FILTER_LEN - 1)) begin
      filt_q <= sync_q[1];
      run_q  <= '0;
    end else begin
      run_q <= run_q + 1'b1;
    end
  end

  assign dout = filt_q;
`else
  assign dout = sync_q[1];
`endif

endmodule

// File: rtl/pwmdir_capture.sv
// pwmdir_capture -- measures a PWM + DIR pin pair and publishes a signed
// high time, the rising-to-rising period and a sticky timeout flag, all in
// clk cycles. One measurement (with a one-cycle valid strobe) per completed
// PWM period; the first period after IDLE is partial and never published.
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   pwmdir_capture_if.slave (enable, PWM, DIR in; feedback out)
// Parameters: TIMEOUT (cycles without a rise before the input is dead, >= 2,
// < 2^31); FILTER_LEN (glitch filter depth, present only when the macro
// PWMDIR_CAPTURE_FILTER_EN is defined).
module pwmdir_capture
  import pwmdir_pkg::*;
#(
  parameter int unsigned TIMEOUT = 400000
`ifdef PWMDIR_CAPTURE_FILTER_EN
  , parameter int unsigned FILTER_LEN = 4
`endif
) (
  input logic             clk,
  input logic             rst,
  pwmdir_capture_if.slave bus
);

  localparam cnt_t TIMEOUT_C = cnt_t'(TIMEOUT);

  logic   pwm_s, dir_s, pwm_prev_q;
  logic   rise, fall, at_limit;
  logic   publish, expire;
  state_t state_q, state_d;
  cnt_t   period_cnt_q, high_cnt_q, hi_latch_q;
  logic   dir_latch_q;
  value_t value_q;
  cnt_t   period_q;
  logic   valid_q, timeout_q;

  pwmdir_in_sync
`ifdef PWMDIR_CAPTURE_FILTER_EN
    #(.FILTER_LEN(FILTER_LEN))
`endif
    u_pwm_sync (.clk(clk), .rst(rst), .din(bus.PWM), .dout(pwm_s));

  pwmdir_in_sync
`ifdef PWMDIR_CAPTURE_FILTER_EN
    #(.FILTER_LEN(FILTER_LEN))
`endif
    u_dir_sync (.clk(clk), .rst(rst), .din(bus.DIR), .dout(dir_s));

  // Edge detection keeps tracking while disabled, so a pin that is already
  // high when enable returns does not look like a fresh rise.
  always_ff @(posedge clk) begin
    if (rst) pwm_prev_q <= 1'b0;
    else     pwm_prev_q <= pwm_s;
  end

  assign rise     = pwm_s & ~pwm_prev_q;
  assign fall     = ~pwm_s & pwm_prev_q;
  assign at_limit = (period_cnt_q == TIMEOUT_C);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    publish = 1'b0;
    expire  = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (rise) state_d = HIGH;   // first period is partial
        HIGH: begin
          if (fall) begin
            state_d = LOW;
          end else if (at_limit) begin
            state_d = IDLE;
            expire  = 1'b1;
          end
        end
        LOW: begin
          // A rise on the very cycle the period saturates still publishes.
          if (rise) begin
            state_d = HIGH;
            publish = 1'b1;
          end else if (at_limit) begin
            state_d = IDLE;
            expire  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.enable) begin
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
    end else if (rise) begin
      period_cnt_q <= cnt_t'(1);
      high_cnt_q   <= cnt_t'(1);
    end else begin
      if (state_q != IDLE && !at_limit)
        period_cnt_q <= period_cnt_q + 1'b1;
      if (state_q == HIGH && pwm_s && high_cnt_q != TIMEOUT_C)
        high_cnt_q <= high_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_latch_q  <= '0;
      dir_latch_q <= 1'b0;
    end else if (bus.enable && state_q == HIGH && fall) begin
      hi_latch_q  <= high_cnt_q;
      dir_latch_q <= dir_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.enable) begin
      value_q   <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (publish) begin
        value_q   <= apply_dir(dir_latch_q, hi_latch_q);
        period_q  <= period_cnt_q;
        valid_q   <= 1'b1;
        timeout_q <= 1'b0;
      end else if (expire) begin
        // Stuck high reports a full-scale high time; stuck low reports zero.
        value_q   <= (state_q == HIGH) ? apply_dir(dir_s, TIMEOUT_C) : '0;
        period_q  <= '0;
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.valueFeedback  = value_q;
  assign bus.periodFeedback = period_q;
  assign bus.valid          = valid_q;
  assign bus.timeout        = timeout_q;

endmodule

// File: tb/tb_pwmdir_capture.sv
// tb_pwmdir_capture -- directed bench for pwmdir_capture. Two instances
// share the same pins: dut_a (TIMEOUT = 1000) for normal measurements and
// dut_t (TIMEOUT = 50) for timeout behaviour.
module tb_pwmdir_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic pwm = 1'b0;
  logic dir = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Captured publishes per instance.
  int a_n, a_val, a_per, a_last, a_prev;
  int t_n, t_val, t_per;

  always #5 clk = ~clk;

  pwmdir_capture_if if_a ();
  pwmdir_capture_if if_t ();

  assign if_a.enable = en;
  assign if_a.PWM    = pwm;
  assign if_a.DIR    = dir;
  assign if_t.enable = en;
  assign if_t.PWM    = pwm;
  assign if_t.DIR    = dir;

  pwmdir_capture #(.TIMEOUT(1000)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  pwmdir_capture #(.TIMEOUT(50))   dut_t (.clk(clk), .rst(rst), .bus(if_t));

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_caps();
    a_n = 0; a_val = 0; a_per = 0; a_last = 0; a_prev = 0;
    t_n = 0; t_val = 0; t_per = 0;
  endtask

  // Drive pins for one cycle, then sample both instances 1 ns after the edge.
  task automatic cycle(input logic p, input logic d);
    pwm = p;
    dir = d;
    @(posedge clk);
    #1;
    cyc++;
    if (if_a.valid) begin
      a_n++;
      a_val  = if_a.valueFeedback;
      a_per  = int'(if_a.periodFeedback);
      a_prev = a_last;
      a_last = cyc;
    end
    if (if_t.valid) begin
      t_n++;
      t_val = if_t.valueFeedback;
      t_per = int'(if_t.periodFeedback);
    end
  endtask

  task automatic hold(input int n, input logic p, input logic d);
    for (int i = 0; i < n; i++) cycle(p, d);
  endtask

  // One PWM period: hi cycles high with DIR = d_hi, then lo cycles low;
  // DIR switches to d_lo five cycles into the low phase.
  task automatic period(input int hi, input int lo, input logic d_hi, input logic d_lo);
    hold(hi, 1'b1, d_hi);
    for (int i = 0; i < lo; i++) cycle(1'b0, (i < 5) ? d_hi : d_lo);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    hold(2, 1'b0, 1'b0);
    rst = 1'b0;
    clear_caps();
  endtask

  initial begin
    clear_caps();

    // Reset state.
    do_reset();
    check("rst_value",   if_a.valueFeedback, 0);
    check("rst_period",  int'(if_a.periodFeedback), 0);
    check("rst_valid",   int'(if_a.valid), 0);
    check("rst_timeout", int'(if_a.timeout), 0);

    // Steady 30/100, DIR = 1: publishes from the second rise, every 100 cycles.
    for (int k = 0; k < 5; k++) period(30, 70, 1'b1, 1'b1);
    check("steady_count",   a_n, 4);
    check("steady_value",   a_val, 30);
    check("steady_period",  a_per, 100);
    check("steady_spacing", a_last - a_prev, 100);

    // Same waveform with DIR = 0.
    do_reset();
    for (int k = 0; k < 4; k++) period(30, 70, 1'b0, 1'b0);
    check("neg_count",  a_n, 3);
    check("neg_value",  a_val, -30);
    check("neg_period", a_per, 100);

    // DIR toggling during the low phase affects only the following publish.
    do_reset();
    period(30, 70, 1'b1, 1'b0);
    period(30, 70, 1'b0, 1'b1);
    check("tog_value1", a_val, 30);
    period(30, 70, 1'b1, 1'b1);
    check("tog_value2", a_val, -30);
    period(30, 70, 1'b1, 1'b1);
    check("tog_value3", a_val, 30);
    check("tog_count",  a_n, 3);

    // PWM held low after one pulse: timeout from LOW.
    do_reset();
    period(10, 80, 1'b1, 1'b1);
    check("tlo_timeout", int'(if_t.timeout), 1);
    check("tlo_value",   if_t.valueFeedback, 0);
    check("tlo_period",  int'(if_t.periodFeedback), 0);
    check("tlo_novalid", t_n, 0);
    period(10, 30, 1'b1, 1'b1);
    check("tlo_sticky",  int'(if_t.timeout), 1);
    period(10, 30, 1'b1, 1'b1);
    check("tlo_recount", t_n, 1);
    check("tlo_cleared", int'(if_t.timeout), 0);
    check("tlo_rvalue",  t_val, 10);
    check("tlo_rperiod", t_per, 40);

    // PWM stuck high with DIR = 0: full-scale negative high time.
    do_reset();
    hold(70, 1'b1, 1'b0);
    check("thi_timeout", int'(if_t.timeout), 1);
    check("thi_value",   if_t.valueFeedback, -50);
    check("thi_period",  int'(if_t.periodFeedback), 0);
    check("thi_novalid", t_n, 0);

    // Period exactly TIMEOUT: the rise wins over the saturation.
    do_reset();
    for (int k = 0; k < 3; k++) period(20, 30, 1'b1, 1'b1);
    check("edge_count",   t_n, 2);
    check("edge_period",  t_per, 50);
    check("edge_value",   t_val, 20);
    check("edge_timeout", int'(if_t.timeout), 0);

    // Period one beyond TIMEOUT: expires before the closing rise.
    do_reset();
    for (int k = 0; k < 2; k++) period(20, 31, 1'b1, 1'b1);
    check("over_count",   t_n, 0);
    check("over_timeout", int'(if_t.timeout), 1);

    // rst mid-HIGH: outputs clear, partial period never published.
    do_reset();
    period(30, 70, 1'b1, 1'b1);
    period(30, 70, 1'b1, 1'b1);
    check("mrst_pre", a_val, 30);
    hold(10, 1'b1, 1'b1);
    rst = 1'b1;
    cycle(1'b0, 1'b1);
    check("mrst_value",   if_a.valueFeedback, 0);
    check("mrst_period",  int'(if_a.periodFeedback), 0);
    check("mrst_timeout", int'(if_a.timeout), 0);
    rst = 1'b0;
    clear_caps();
    hold(60, 1'b0, 1'b1);
    period(30, 70, 1'b1, 1'b1);
    check("mrst_nopartial", a_n, 0);
    period(30, 70, 1'b1, 1'b1);
    check("mrst_count",  a_n, 1);
    check("mrst_rvalue", a_val, 30);
    check("mrst_rper",   a_per, 100);

    // enable = 0 mid-HIGH: same behaviour, pin stays high while disabled.
    do_reset();
    period(30, 70, 1'b1, 1'b1);
    period(30, 70, 1'b1, 1'b1);
    hold(10, 1'b1, 1'b1);
    en = 1'b0;
    cycle(1'b1, 1'b1);
    check("dis_value",  if_a.valueFeedback, 0);
    check("dis_period", int'(if_a.periodFeedback), 0);
    check("dis_valid",  int'(if_a.valid), 0);
    hold(2, 1'b1, 1'b1);
    en = 1'b1;
    clear_caps();
    hold(17, 1'b1, 1'b1);
    hold(70, 1'b0, 1'b1);
    period(30, 70, 1'b1, 1'b1);
    check("dis_nopartial", a_n, 0);
    period(30, 70, 1'b1, 1'b1);
    check("dis_count",  a_n, 1);
    check("dis_rvalue", a_val, 30);
    check("dis_rper",   a_per, 100);

`ifdef PWMDIR_CAPTURE_FILTER_EN
    // 2-cycle high glitch in the low phase is suppressed.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      hold(30, 1'b1, 1'b1);
      hold(20, 1'b0, 1'b1);
      hold(2,  1'b1, 1'b1);
      hold(48, 1'b0, 1'b1);
    end
    check("glo_count",  a_n, 2);
    check("glo_value",  a_val, 30);
    check("glo_period", a_per, 100);

    // 2-cycle low glitch in the high phase is suppressed.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      hold(10, 1'b1, 1'b1);
      hold(2,  1'b0, 1'b1);
      hold(18, 1'b1, 1'b1);
      hold(70, 1'b0, 1'b1);
    end
    check("ghi_value",  a_val, 30);
    check("ghi_period", a_per, 100);

    // A 6-cycle pulse passes the filter intact.
    do_reset();
    for (int k = 0; k < 3; k++) period(6, 94, 1'b1, 1'b1);
    check("p6_value",  a_val, 6);
    check("p6_period", a_per, 100);
`else
    // Minimum 1-cycle high time.
    do_reset();
    for (int k = 0; k < 3; k++) period(1, 99, 1'b1, 1'b1);
    check("min_hi_value",  a_val, 1);
    check("min_hi_period", a_per, 100);

    // Minimum 1-cycle low time.
    do_reset();
    for (int k = 0; k < 3; k++) period(99, 1, 1'b0, 1'b0);
    check("min_lo_value",  a_val, -99);
    check("min_lo_period", a_per, 100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
